// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parametrised serial pattern detector with match counter; optional macro SEQ_DET_CNT_SAT_EN selects a saturating counter
module seq_detector_param #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             id,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             clr_cnt,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy
);

    // fill must be able to hold the value PAT_W itself
    localparam int FW = $clog2(PAT_W + 1);

    logic [PAT_W-1:0] hist;
    logic [PAT_W-1:0] pattern;
    logic [FW-1:0]    fill;

    logic [PAT_W-1:0] nh;
    logic [FW-1:0]    nf;
    logic             hit;
    logic [CNT_W-1:0] cnt_inc;

    // next history/fill if this bit is accepted, and whether it completes a match
    always_comb begin
        nh  = {hist[PAT_W-2:0], id};
        nf  = (fill == FW'(PAT_W)) ? fill : fill + FW'(1);
        hit = (nf == FW'(PAT_W)) && (nh == pattern);
    end

    // counter value after one more match: saturating or wrapping
    always_comb begin
`ifdef SEQ_DET_CNT_SAT_EN
        cnt_inc = (match_cnt == {CNT_W{1'b1}}) ? match_cnt : match_cnt + CNT_W'(1);
`else
        cnt_inc = match_cnt + CNT_W'(1);
`endif
    end

    // pattern load beats bit acceptance; a match without overlap restarts history from empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist      <= '0;
            fill      <= '0;
            pattern   <= PATTERN;
            out       <= 1'b0;
            match_cnt <= '0;
        end else begin
            if (pat_load) begin
                pattern <= pat_in;
                hist    <= '0;
                fill    <= '0;
                out     <= 1'b0;
            end else if (en) begin
                out <= hit;
                if (hit && !overlap) begin
                    hist <= '0;
                    fill <= '0;
                end else begin
                    hist <= nh;
                    fill <= nf;
                end
            end else begin
                out <= 1'b0;
            end

            // clear wins over a same-cycle increment
            if (clr_cnt)
                match_cnt <= '0;
            else if (!pat_load && en && hit)
                match_cnt <= cnt_inc;
        end
    end

    assign busy = (fill != '0);

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - scoreboard bench for seq_detector_param against a bit-list reference model
module tb_seq_detector_param;

    localparam int PAT_W = 4;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             id = 1'b0;
    logic             overlap = 1'b0;
    logic             pat_load = 1'b0;
    logic [PAT_W-1:0] pat_in = '0;
    logic             clr_cnt = 1'b0;
    logic             out;
    logic [CNT_W-1:0] match_cnt;
    logic             busy;

    seq_detector_param #(
        .PAT_W   (PAT_W),
        .PATTERN (4'b1011),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .id        (id),
        .overlap   (overlap),
        .pat_load  (pat_load),
        .pat_in    (pat_in),
        .clr_cnt   (clr_cnt),
        .out       (out),
        .match_cnt (match_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic out;
        int   cnt;
        logic busy;
        int   tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   tag_ctr = 0;

    // reference model: the valid bits seen since the last clear, newest at the back
    bit   m_bits[$];
    int   m_pat;
    int   m_cnt;

    task automatic check(input string name, input logic a_out, input int a_cnt, input logic a_busy,
                         input logic e_out, input int e_cnt, input logic e_busy);
        n_checks++;
        if (a_out === e_out && a_cnt == e_cnt && a_busy === e_busy)
            n_pass++;
        else
            $display("FAIL %s: out/cnt/busy got %b/%0d/%b required %b/%0d/%b",
                     name, a_out, a_cnt, a_busy, e_out, e_cnt, e_busy);
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_pat = 'hB;
        m_cnt = 0;
    endtask

    // one clock of stimulus: drive inputs, advance the model, queue the expected response
    task automatic step(input logic e, input logic b, input logic ov, input logic ld,
                        input int pin, input logic clr);
        int   v;
        logic m;
        exp_t x;
        @(negedge clk);
        en = e; id = b; overlap = ov; pat_load = ld; pat_in = pin[PAT_W-1:0]; clr_cnt = clr;
        m = 1'b0;
        if (ld) begin
            m_pat = pin % (1 << PAT_W);
            m_bits.delete();
        end else if (e) begin
            m_bits.push_back(b);
            if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
            if (m_bits.size() == PAT_W) begin
                v = 0;
                foreach (m_bits[k]) v = v * 2 + int'(m_bits[k]);
                if (v == m_pat) begin
                    m = 1'b1;
                    if (!ov) m_bits.delete();
                end
            end
        end
        if (clr)
            m_cnt = 0;
        else if (m) begin
`ifdef SEQ_DET_CNT_SAT_EN
            if (m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
`else
            m_cnt = (m_cnt + 1) % (1 << CNT_W);
`endif
        end
        x.out = m; x.cnt = m_cnt; x.busy = (m_bits.size() != 0); x.tag = tag_ctr++;
        exp_q.push_back(x);
    endtask

    task automatic stream(input string s, input logic ov);
        for (int i = 0; i < s.len(); i++)
            step(1'b1, s[i] == "1", ov, 1'b0, 0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    // monitor: every registered response is compared with the oldest queued expectation
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (exp_q.size() != 0) begin
            x = exp_q.pop_front();
            check($sformatf("cycle%0d", x.tag), out, int'(match_cnt), busy, x.out, x.cnt, x.busy);
        end
    end

    initial begin
        model_reset();
        #1;
        check("reset_async", out, int'(match_cnt), busy, 1'b0, 0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // overlap: 1011011 -> two matches
        stream("1011011", 1'b1);
        // no overlap on the same stream, history cleared by a load of the same pattern
        step(1'b0, 1'b0, 1'b0, 1'b1, 'hB, 1'b0);
        stream("1011011", 1'b0);
        // near-miss prefix, single late match
        step(1'b0, 1'b0, 1'b0, 1'b1, 'hB, 1'b1);
        stream("101011", 1'b1);
        // en gaps between valid bits
        step(1'b0, 1'b0, 1'b0, 1'b1, 'hB, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        idle(2);
        // six non-overlapping matches exercise counter wrap / saturation
        step(1'b0, 1'b0, 1'b0, 1'b1, 'hB, 1'b1);
        for (int i = 0; i < 6; i++) stream("1011", 1'b0);
        // clear together with a match: count 0, pulse still present
        stream("101", 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1);
        // self-overlapping pattern fires on every bit once full
        step(1'b0, 1'b0, 1'b1, 1'b1, 'hF, 1'b0);
        stream("1111111", 1'b1);
        // run-time pattern, then asynchronous reset mid-stream restores the default
        step(1'b0, 1'b0, 1'b1, 1'b1, 'h6, 1'b0);
        stream("0110110", 1'b1);
        stream("01", 1'b1);
        @(posedge clk);
        #3;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_mid_stream", out, int'(match_cnt), busy, 1'b0, 0, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        stream("1011", 1'b1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 39) == 0,
                 int'($urandom_range(0, 15)), $urandom_range(0, 24) == 0);
        end

        @(posedge clk);
        #3;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
